// File: rtl/melody_sequencer.sv
// Song ROM player: fetches {dur,note} slots and drives the tone generator note index.
// Optional MELODY_LOOP_EN: replay the song from entry 0 until stop instead of returning to idle.
module melody_sequencer #(
  parameter int unsigned TICKS_PER_UNIT = 12500000,
  parameter int unsigned GAP_TICKS      = 500000,
  parameter int unsigned SONG_LEN       = 64,
  parameter int unsigned ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic [4:0]        note_j,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [TW-1:0]     PLAY_LAST = TW'(TICKS_PER_UNIT - GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_FINISH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [4:0]        r_note;
  logic [TW-1:0]     r_tick;
  logic [3:0]        r_units;
  logic [3:0]        w_dur;
  logic [4:0]        w_note;
  logic              w_tick_last;
  logic              w_play_end;

  assign w_dur       = rom_data[8:5];
  assign w_note      = rom_data[4:0];
  assign w_tick_last = (r_tick == TICK_LAST);
  // PLAY ends GAP_TICKS before the last unit's terminal tick; GAP runs the remainder.
  assign w_play_end  = (r_units == 4'd0) && (r_tick == PLAY_LAST);

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = (w_dur == 4'd0) ? S_FINISH : S_PLAY;
      S_PLAY:  if (!pause && w_play_end) w_next = S_GAP;
      S_GAP: begin
        if (!pause && w_tick_last) begin
          if (r_idx == IDX_LAST) begin
            w_next = S_FINISH;
          end else begin
            w_next     = S_FETCH;
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      S_FINISH: begin
        w_idx_next = '0;
`ifdef MELODY_LOOP_EN
        w_next = S_FETCH;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
    if (stop) begin
      w_next     = S_IDLE;
      w_idx_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_note     <= '0;
      r_tick     <= '0;
      r_units    <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      if (w_next == S_FETCH) r_rom_addr <= w_idx_next;

      if (r_state == S_LOAD && w_next == S_PLAY)
        r_note <= (w_note >= 5'd1 && w_note <= 5'd28) ? w_note : 5'd0;
      else if (w_next != S_PLAY)
        r_note <= '0;

      case (r_state)
        S_LOAD: begin
          if (w_dur != 4'd0) begin
            r_tick  <= '0;
            r_units <= w_dur - 4'd1;
          end
        end
        S_PLAY, S_GAP: begin
          if (!pause) begin
            if (w_tick_last) begin
              r_tick <= '0;
              if (r_units != 4'd0) r_units <= r_units - 4'd1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (stop) begin
        r_tick  <= '0;
        r_units <= '0;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign note_j   = pause ? 5'd0 : r_note;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FINISH) && !stop;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with short tick parameters and a registered song ROM model.
module tb_melody_sequencer;
  localparam int T  = 10;
  localparam int G  = 2;
  localparam int SL = 4;
  localparam int AW = 3;
`ifdef MELODY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, stop, pause;
  logic [AW-1:0] rom_addr;
  logic [8:0]    rom_data;
  logic [4:0]    note_j;
  logic          busy, done;
  logic [8:0]    rom [0:7];

  logic [4:0]    tr_note [0:127];
  logic [AW-1:0] tr_addr [0:127];
  logic          tr_busy [0:127];
  logic          tr_done [0:127];

  int n_chk = 0;
  int n_err = 0;

  melody_sequencer #(
    .TICKS_PER_UNIT(T), .GAP_TICKS(G), .SONG_LEN(SL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_j(note_j),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] win(input int lo, input int n);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i < lo + n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Cycle c is the clock period whose closing edge samples the inputs driven for c.
  task automatic run(input int ncyc, input logic [127:0] st_m, input logic [127:0] sp_m,
                     input logic [127:0] pa_m);
    for (int c = 0; c < ncyc; c++) begin
      start = st_m[c];
      stop  = sp_m[c] || (c == ncyc - 1);
      pause = pa_m[c];
      #1;
      tr_note[c] = note_j;
      tr_addr[c] = rom_addr;
      tr_busy[c] = busy;
      tr_done[c] = done;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic exp_note(input string tag, input int lo, input int hi, input int v);
    for (int c = lo; c <= hi; c++) check($sformatf("%s note c%0d", tag, c), tr_note[c], v);
  endtask

  task automatic exp_done(input string tag, input int n, input int at1, input int at2);
    for (int c = 0; c < n; c++)
      check($sformatf("%s done c%0d", tag, c), tr_done[c], (c == at1) || (c == at2));
  endtask

  task automatic load_song_a();
    for (int i = 0; i < 8; i++) rom[i] = 9'd0;
    rom[0] = {4'd2, 5'd8};
    rom[1] = {4'd1, 5'd12};
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 9'd0;
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst note %0d", i), note_j, 0);
      check($sformatf("rst busy %0d", i), busy, 0);
      check($sformatf("rst done %0d", i), done, 0);
      check($sformatf("rst addr %0d", i), rom_addr, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-note song with end marker
    load_song_a();
    run(46, win(0, 1), '0, '0);
    check("A busy c0", tr_busy[0], 0);
    check("A addr c1", tr_addr[1], 0);
    check("A busy c1", tr_busy[1], 1);
    exp_note("A", 0, 2, 0);
    exp_note("A", 3, 20, 8);
    exp_note("A", 21, 24, 0);
    check("A addr c23", tr_addr[23], 1);
    exp_note("A", 25, 32, 12);
    exp_note("A", 33, 36, 0);
    check("A addr c35", tr_addr[35], 2);
    exp_done("A", 45, 37, 37);
    check("A busy c37", tr_busy[37], 1);
    check("A busy c38", tr_busy[38], LOOP);

    // Pause for 5 cycles during the first note
    load_song_a();
    run(40, win(0, 1), '0, win(6, 5));
    exp_note("B", 3, 5, 8);
    exp_note("B", 6, 10, 0);
    exp_note("B", 11, 25, 8);
    exp_note("B", 26, 27, 0);
    check("B addr c28", tr_addr[28], 1);
    check("B note c30", tr_note[30], 12);

    // Stop, simultaneous start+stop while idle, restart, stop in second note
    load_song_a();
    run(50, win(0, 1) | win(12, 1) | win(14, 1) | win(43, 1), win(10, 1) | win(12, 1) | win(40, 1), '0);
    check("C note c10", tr_note[10], 8);
    check("C note c11", tr_note[11], 0);
    check("C busy c11", tr_busy[11], 0);
    check("C busy c13", tr_busy[13], 0);
    check("C addr c15", tr_addr[15], 0);
    check("C busy c15", tr_busy[15], 1);
    exp_note("C", 17, 34, 8);
    check("C addr c37", tr_addr[37], 1);
    check("C note c39", tr_note[39], 12);
    check("C note c41", tr_note[41], 0);
    check("C busy c41", tr_busy[41], 0);
    check("C addr c41", tr_addr[41], 1);
    check("C addr c44", tr_addr[44], 0);
    exp_done("C", 49, -1, -1);

    // Full-length song without end marker
    for (int i = 0; i < 4; i++) rom[i] = {4'd1, 5'd5};
    rom[4] = {4'd1, 5'd9};
    run(110, win(0, 1), '0, '0);
    for (int c = 0; c < 109; c++) check($sformatf("D addr<4 c%0d", c), tr_addr[c] >= 4, 0);
    for (int s = 0; s < 4; s++) begin
      exp_note($sformatf("D s%0d", s), 3 + 12 * s, 10 + 12 * s, 5);
      exp_note($sformatf("D s%0d", s), 11 + 12 * s, 14 + 12 * s, 0);
      check($sformatf("D addr slot %0d", s), tr_addr[1 + 12 * s], s);
    end
    exp_done("D", 108, 49, LOOP ? 98 : 49);
    check("D busy c49", tr_busy[49], 1);
    check("D busy c50", tr_busy[50], LOOP);
    check("D note c52", tr_note[52], LOOP ? 5 : 0);

    // Out-of-range note is a rest; start mid-song is ignored
    for (int i = 0; i < 8; i++) rom[i] = 9'd0;
    rom[0] = {4'd1, 5'd30};
    rom[1] = {4'd2, 5'd7};
    run(45, win(0, 1) | win(5, 1) | win(20, 1), '0, '0);
    exp_note("E", 3, 10, 0);
    check("E addr c13", tr_addr[13], 1);
    exp_note("E", 15, 32, 7);
    check("E note c33", tr_note[33], 0);
    check("E addr c35", tr_addr[35], 2);
    exp_done("E", 44, 37, 37);

    // Start together with pause from idle
    load_song_a();
    run(40, win(0, 1), '0, win(0, 5));
    check("F addr c1", tr_addr[1], 0);
    exp_note("F", 0, 4, 0);
    exp_note("F", 5, 22, 8);
    exp_note("F", 23, 24, 0);
    check("F addr c25", tr_addr[25], 1);
    check("F note c27", tr_note[27], 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
